// File: rtl/player_input_pkg.sv
// player_input_pkg: shared types and constants for the player input controller.
//   state_e    - FSM state encoding (3 bits, exported on the debug `state` port)
//   CHARGE_W   - width of the jump charge level
//   DIR_*      - signed walk direction constants
//   decode_dir - maps debounced left/right levels to a direction
package player_input_pkg;

  localparam int unsigned CHARGE_W = 5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWalk   = 3'd1,
    StCharge = 3'd2,
    StLaunch = 3'd3,
    StAir    = 3'd4
  } state_e;

  localparam logic signed [1:0] DIR_LEFT  = -2'sd1;
  localparam logic signed [1:0] DIR_NONE  = 2'sd0;
  localparam logic signed [1:0] DIR_RIGHT = 2'sd1;

  // Both or neither button cancels out to no motion.
  function automatic logic signed [1:0] decode_dir(input logic left, input logic right);
    logic signed [1:0] dir;
    dir = DIR_NONE;
    if (left && !right) dir = DIR_LEFT;
    if (right && !left) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus optional stable-time debouncer for one button.
// Configuration macro: PLAYER_INPUT_DEBOUNCE_EN
//   defined   - level changes after the synchronized input is stable DEBOUNCE_CYC cycles
//   undefined - level is the synchronizer output (2-cycle latency), DEBOUNCE_CYC unused
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (level resets to released)
//   btn_i   - raw asynchronous button
//   level_o - debounced level
//   rise_o  - one-cycle pulse, coincident with level_o going high
//   fall_o  - one-cycle pulse, coincident with level_o going low
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;

`ifdef PLAYER_INPUT_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;

  // Any disagreement with the current level that does not last the full window
  // clears the counter, so bounces restart the stability count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
`else
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;
`endif

endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns left/right/jump buttons into one motion command per frame,
// with hold-to-charge jumping, handed to physics over a valid/ready handshake.
// Configuration macro: PLAYER_INPUT_DEBOUNCE_EN (see btn_debounce).
// Ports:
//   sys_clk, sys_rst                 - clock, synchronous active-high reset
//   left_btn, right_btn, jump_btn    - raw buttons
//   frame_tick                       - one-cycle frame start pulse
//   on_ground                        - physics ground contact, valid at frame_tick
//   cmd_valid/cmd_ready              - command handshake
//   cmd_vx, cmd_vy, cmd_jump         - command payload (negative vy is up)
//   charge_level, face_left, state   - HUD, sprite orientation, debug state
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC       = 1_000_000,
  parameter int unsigned CHARGE_MAX         = 31,
  parameter int unsigned CHARGE_STEP_FRAMES = 2,
  parameter int unsigned WALK_SPEED         = 2,
  parameter int unsigned JUMP_BASE          = 4,
  parameter int unsigned VEL_W              = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       left_btn,
  input  logic                       right_btn,
  input  logic                       jump_btn,
  input  logic                       frame_tick,
  input  logic                       on_ground,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic signed [VEL_W-1:0]    cmd_vx,
  output logic signed [VEL_W-1:0]    cmd_vy,
  output logic                       cmd_jump,
  output logic        [CHARGE_W-1:0] charge_level,
  output logic                       face_left,
  output logic        [2:0]          state
);

  localparam int unsigned StepW = (CHARGE_STEP_FRAMES > 1) ? $clog2(CHARGE_STEP_FRAMES) : 1;

  logic left_lvl, left_rise, left_fall;
  logic right_lvl, right_rise, right_fall;
  logic jump_lvl, jump_rise, jump_fall;
  logic unused_edges;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_left (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .btn_i  (left_btn),
    .level_o(left_lvl),
    .rise_o (left_rise),
    .fall_o (left_fall)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_right (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .btn_i  (right_btn),
    .level_o(right_lvl),
    .rise_o (right_rise),
    .fall_o (right_fall)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_jump (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .btn_i  (jump_btn),
    .level_o(jump_lvl),
    .rise_o (jump_rise),
    .fall_o (jump_fall)
  );

  assign unused_edges = ^{jump_lvl, left_rise, left_fall, right_rise, right_fall};

  state_e                   state_q, state_d;
  logic     [CHARGE_W-1:0]  charge_q, charge_d;
  logic     [StepW-1:0]     step_q, step_d;
  logic signed [1:0]        launch_dir_q, launch_dir_d;
  logic                     face_q, face_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic signed [VEL_W-1:0]  cmd_vx_q, cmd_vx_d;
  logic signed [VEL_W-1:0]  cmd_vy_q, cmd_vy_d;
  logic                     cmd_jump_q, cmd_jump_d;

  logic signed [1:0]        dir;
  logic signed [VEL_W-1:0]  walk_vx, launch_vx, launch_vy;
  logic                     load;
  logic signed [VEL_W-1:0]  new_vx, new_vy;
  logic                     new_jump;
  logic                     launch_pending;

  assign dir       = decode_dir(left_lvl, right_lvl);
  assign walk_vx   = VEL_W'(int'(dir) * int'(WALK_SPEED));
  assign launch_vx = VEL_W'(int'(launch_dir_q) * int'(charge_q >> 2));
  assign launch_vy = VEL_W'(-(int'(JUMP_BASE) + int'(charge_q)));

  // A launch waiting for physics must never be replaced by a later frame's command.
  assign launch_pending = cmd_valid_q & cmd_jump_q;

  always_comb begin
    state_d      = state_q;
    charge_d     = charge_q;
    step_d       = step_q;
    launch_dir_d = launch_dir_q;
    face_d       = face_q;
    cmd_valid_d  = cmd_valid_q & ~cmd_ready;
    cmd_vx_d     = cmd_vx_q;
    cmd_vy_d     = cmd_vy_q;
    cmd_jump_d   = cmd_jump_q;
    load         = 1'b0;
    new_vx       = '0;
    new_vy       = '0;
    new_jump     = 1'b0;

    if (dir != DIR_NONE) face_d = (dir == DIR_LEFT);

    unique case (state_q)
      StIdle, StWalk: begin
        state_d = (dir != DIR_NONE) ? StWalk : StIdle;
        if (frame_tick) begin
          load = 1'b1;
          if (!on_ground) state_d = StAir;
          else            new_vx  = walk_vx;
        end
        if (jump_rise && on_ground) begin
          state_d  = StCharge;
          charge_d = '0;
          step_d   = '0;
        end
      end
      StCharge: begin
        if (frame_tick && !on_ground) begin
          load     = 1'b1;
          state_d  = StAir;
          charge_d = '0;
          step_d   = '0;
        end else begin
          if (frame_tick) begin
            load = 1'b1;
            if (step_q == StepW'(CHARGE_STEP_FRAMES - 1)) begin
              step_d = '0;
              if (charge_q < CHARGE_W'(CHARGE_MAX)) charge_d = charge_q + 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
          if (jump_fall) begin
            state_d      = StLaunch;
            launch_dir_d = dir;
          end
        end
      end
      StLaunch: begin
        if (frame_tick && !launch_pending) begin
          load     = 1'b1;
          new_vx   = launch_vx;
          new_vy   = launch_vy;
          new_jump = 1'b1;
        end
        if (launch_pending && cmd_ready) begin
          state_d  = StAir;
          charge_d = '0;
          step_d   = '0;
        end
      end
      StAir: begin
        if (frame_tick) begin
          load = 1'b1;
          if (on_ground) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_vx_d    = new_vx;
      cmd_vy_d    = new_vy;
      cmd_jump_d  = new_jump;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      charge_q     <= '0;
      step_q       <= '0;
      launch_dir_q <= DIR_NONE;
      face_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_vx_q     <= '0;
      cmd_vy_q     <= '0;
      cmd_jump_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      charge_q     <= charge_d;
      step_q       <= step_d;
      launch_dir_q <= launch_dir_d;
      face_q       <= face_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_vx_q     <= cmd_vx_d;
      cmd_vy_q     <= cmd_vy_d;
      cmd_jump_q   <= cmd_jump_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_vx       = cmd_vx_q;
  assign cmd_vy       = cmd_vy_q;
  assign cmd_jump     = cmd_jump_q;
  assign charge_level = charge_q;
  assign face_left    = face_q;
  assign state        = state_q;

endmodule
